// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard.
// Tracks, per architectural register, how many cycles remain until an in-flight
// result is written back, and raises a combinational stall for RAW and WAW
// hazards against the instruction currently held in decode.
// Counter semantics: an issue at edge E loads rd_lat, and every following edge
// decrements it by one. A register reads busy while its counter is nonzero.
module id_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned LAT_W  = 3,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_issue_valid,
  input  logic                   i_rs1_en,
  input  logic                   i_rs2_en,
  input  logic [AW-1:0]          i_rs1_addr,
  input  logic [AW-1:0]          i_rs2_addr,
  input  logic                   i_rd_en,
  input  logic [AW-1:0]          i_rd_addr,
  input  logic [LAT_W-1:0]       i_rd_lat,
  output logic                   o_stall,
  output logic                   o_issue_fire,
  output logic [NREG-1:0]        o_busy,
  output logic [$clog2(NREG):0]  o_busy_count
);

  localparam int unsigned CW = $clog2(NREG) + 1;
  localparam logic [LAT_W-1:0] CntOne = LAT_W'(1);

  // Per-register remaining-latency counters; entry 0 is never loaded.
  logic [LAT_W-1:0] r_cnt   [NREG];
  logic [LAT_W-1:0] w_cnt_d [NREG];
  logic [CW-1:0]    r_busy_count;
  logic [CW-1:0]    w_pop_d;

  logic [LAT_W-1:0] w_rs1_cnt;
  logic [LAT_W-1:0] w_rs2_cnt;
  logic [LAT_W-1:0] w_rd_cnt;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_track;
  logic             w_waw;
  logic             w_load;

  // Hazard detection from current counters and current decode inputs only.
  always_comb begin
    w_rs1_cnt = r_cnt[i_rs1_addr];
    w_rs2_cnt = r_cnt[i_rs2_addr];
    w_rd_cnt  = r_cnt[i_rd_addr];

    // With forwarding, a result one cycle from writeback is already usable.
    w_raw1 = i_rs1_en && (i_rs1_addr != '0) &&
             (FWD_EN ? (w_rs1_cnt > CntOne) : (w_rs1_cnt != '0));
    w_raw2 = i_rs2_en && (i_rs2_addr != '0) &&
             (FWD_EN ? (w_rs2_cnt > CntOne) : (w_rs2_cnt != '0));

    // A zero latency or x0 destination is never tracked.
    w_track = i_rd_en && (i_rd_addr != '0) && (i_rd_lat != '0);
    // An older write that would land at or after ours must not overwrite it.
    w_waw   = w_track && (w_rd_cnt >= i_rd_lat);

    o_stall      = i_issue_valid && (w_raw1 || w_raw2 || w_waw);
    o_issue_fire = i_issue_valid && !o_stall && !i_flush;
    w_load       = o_issue_fire && w_track;
  end

  // Next counter values: decrement, then issue load, then flush squash.
  always_comb begin
    w_pop_d = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_d[i] = (r_cnt[i] != '0) ? (r_cnt[i] - CntOne) : '0;
      if (w_load && (i_rd_addr == AW'(i))) begin
        w_cnt_d[i] = i_rd_lat;
      end
      if (i_flush || (i == 0)) begin
        w_cnt_d[i] = '0;
      end
      w_pop_d = w_pop_d + CW'(w_cnt_d[i] != '0);
    end
  end

  // State update; reset dominates flush and issue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_busy_count <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
      // Popcount of the post-edge counters, so it matches o_busy in the same cycle.
      r_busy_count <= w_pop_d;
    end
  end

  // Busy vector straight from the counters.
  always_comb begin
    o_busy = '0;
    for (int i = 0; i < NREG; i++) begin
      o_busy[i] = (r_cnt[i] != '0);
    end
  end

  assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: two instances share stimulus, one with
// forwarding enabled and one without. Inputs change 1ns after the rising edge;
// outputs are checked on the falling edge.
module tb_id_scoreboard;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        rs1_en;
  logic        rs2_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_lat;

  logic        stall_f, fire_f, stall_n, fire_n;
  logic [31:0] busy_f, busy_n;
  logic [5:0]  cnt_f, cnt_n;

  int errors = 0;
  int checks = 0;

  id_scoreboard #(.NREG(32), .LAT_W(3), .FWD_EN(1'b1)) u_fwd (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_flush      (flush),
    .i_issue_valid(issue_valid),
    .i_rs1_en     (rs1_en),
    .i_rs2_en     (rs2_en),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .i_rd_en      (rd_en),
    .i_rd_addr    (rd_addr),
    .i_rd_lat     (rd_lat),
    .o_stall      (stall_f),
    .o_issue_fire (fire_f),
    .o_busy       (busy_f),
    .o_busy_count (cnt_f)
  );

  id_scoreboard #(.NREG(32), .LAT_W(3), .FWD_EN(1'b0)) u_nofwd (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_flush      (flush),
    .i_issue_valid(issue_valid),
    .i_rs1_en     (rs1_en),
    .i_rs2_en     (rs2_en),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .i_rd_en      (rd_en),
    .i_rd_addr    (rd_addr),
    .i_rd_lat     (rd_lat),
    .o_stall      (stall_n),
    .o_issue_fire (fire_n),
    .o_busy       (busy_n),
    .o_busy_count (cnt_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    rs1_en      = 1'b0;
    rs2_en      = 1'b0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    rd_lat      = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    idle();
    // Reset together with flush and a tracked issue: reset must win.
    reset = 1'b1; flush = 1'b1; issue_valid = 1'b1;
    rd_en = 1'b1; rd_addr = 5'd5; rd_lat = 3'd3;
    next_cycle();
    mid();
    chk("reset_busy",       busy_f, 0);
    chk("reset_busy_count", cnt_f, 0);
    chk("reset_stall",      stall_f, 0);
    chk("reset_fire",       fire_f, 0);
    next_cycle();
    reset = 1'b0;
    idle();
    mid();
    chk("post_reset_busy_n", busy_n, 0);
    next_cycle();

    // Producer rd=5 lat=3, dependent on rs1=5 from the next cycle.
    // Counter reads 3,2,1,0 in the following cycles.
    issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd5; rd_lat = 3'd3;
    mid();
    chk("prod_fire_f", fire_f, 1);
    chk("prod_fire_n", fire_n, 1);
    next_cycle();
    idle(); issue_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 5'd5;
    mid();
    chk("dep_c1_stall_f", stall_f, 1);
    chk("dep_c1_stall_n", stall_n, 1);
    chk("dep_c1_busy5",   busy_f[5], 1);
    chk("dep_c1_count",   cnt_f, 1);
    next_cycle();
    mid();
    chk("dep_c2_stall_f", stall_f, 1);
    chk("dep_c2_stall_n", stall_n, 1);
    chk("dep_c2_busy5",   busy_f[5], 1);
    next_cycle();
    mid();
    chk("dep_c3_fire_f",  fire_f, 1);
    chk("dep_c3_stall_n", stall_n, 1);
    chk("dep_c3_busy5",   busy_f[5], 1);
    next_cycle();
    mid();
    chk("dep_c4_fire_n",  fire_n, 1);
    chk("dep_c4_busy5",   busy_n[5], 0);
    chk("dep_c4_count",   cnt_f, 0);
    next_cycle();

    // x0 is never tracked.
    idle(); issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd0; rd_lat = 3'd4;
    mid();
    chk("x0_fire", fire_f, 1);
    next_cycle();
    idle(); issue_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 5'd0;
    mid();
    chk("x0_stall_f", stall_f, 0);
    chk("x0_stall_n", stall_n, 0);
    chk("x0_busy",    busy_f, 0);
    chk("x0_count",   cnt_f, 0);
    next_cycle();

    // WAW: rd=7 lat=4, then rd=7 against counter values 4 and 3.
    idle(); issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd7; rd_lat = 3'd4;
    mid();
    chk("waw_prod_fire", fire_f, 1);
    next_cycle();
    rd_lat = 3'd2;
    mid();
    chk("waw_lat2_stall_f", stall_f, 1);
    chk("waw_lat2_stall_n", stall_n, 1);
    chk("waw_lat2_fire",    fire_f, 0);
    next_cycle();
    rd_lat = 3'd4;
    mid();
    chk("waw_lat4_stall", stall_f, 0);
    chk("waw_lat4_fire",  fire_f, 1);
    next_cycle();
    // Reloaded to 4: rs2 path sees a hazard in both instances.
    idle(); issue_valid = 1'b1; rs2_en = 1'b1; rs2_addr = 5'd7;
    mid();
    chk("reload_rs2_stall_f", stall_f, 1);
    chk("reload_rs2_stall_n", stall_n, 1);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    // Counter is now 1: forwardable, but still busy.
    issue_valid = 1'b1; rs2_en = 1'b1; rs2_addr = 5'd7;
    mid();
    chk("reload_c1_busy7",  busy_f[7], 1);
    chk("reload_c1_stall_f", stall_f, 0);
    chk("reload_c1_stall_n", stall_n, 1);
    next_cycle();
    idle();
    mid();
    chk("reload_done_busy7", busy_f[7], 0);
    chk("reload_done_count", cnt_f, 0);
    next_cycle();

    // Flush with three writes in flight.
    issue_valid = 1'b1; rd_en = 1'b1; rd_lat = 3'd5; rd_addr = 5'd3;
    next_cycle();
    rd_addr = 5'd4;
    next_cycle();
    rd_addr = 5'd9;
    next_cycle();
    idle(); flush = 1'b1; issue_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 5'd3;
    mid();
    chk("flush_pre_busy",  busy_f, 32'h0000_0218);
    chk("flush_pre_count", cnt_f, 3);
    chk("flush_fire",      fire_f, 0);
    next_cycle();
    flush = 1'b0;
    mid();
    chk("flush_post_busy",  busy_f, 0);
    chk("flush_post_count", cnt_n, 0);
    chk("flush_post_stall", stall_f, 0);
    chk("flush_post_fire",  fire_n, 1);
    next_cycle();

    // Flush suppresses an otherwise hazard-free tracked issue.
    idle(); flush = 1'b1; issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd12; rd_lat = 3'd5;
    mid();
    chk("flush_dom_stall", stall_f, 0);
    chk("flush_dom_fire",  fire_f, 0);
    next_cycle();
    idle();
    mid();
    chk("flush_dom_busy", busy_f, 0);
    next_cycle();

    // Mid-operation reset discards a max-latency write.
    issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd10; rd_lat = 3'd7;
    next_cycle();
    idle();
    next_cycle();
    reset = 1'b1; issue_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd11; rd_lat = 3'd3;
    mid();
    chk("rst_mid_pre_count", cnt_f, 1);
    next_cycle();
    reset = 1'b0;
    idle(); issue_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 5'd10;
    mid();
    chk("rst_mid_busy",    busy_f, 0);
    chk("rst_mid_count",   cnt_f, 0);
    chk("rst_mid_stall_f", stall_f, 0);
    chk("rst_mid_stall_n", stall_n, 0);
    chk("rst_mid_fire",    fire_n, 1);
    next_cycle();
    idle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
